// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register sequencer and the universal
// shift register it drives: FSM state encoding and register command codes.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Universal shift register commands
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SHL  = 2'b01;
    localparam logic [1:0] SR_SHR  = 2'b10;
    localparam logic [1:0] SR_LOAD = 2'b11;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Sequencer for an N-bit universal shift register.
// Takes a word on the start handshake, parallel-loads it into the register,
// issues N shift commands (word leaves on ser_out while ser_in is shifted in),
// then offers the received word (read straight from sr_q) on the done handshake.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start_valid/ready     start handshake; dir and load_data sampled here
//   dir                   0 = shift left (MSB out first), 1 = shift right
//   load_data             word to transmit
//   ser_in / ser_out      serial receive / transmit bit
//   sr_ctrl, sr_d, sr_q   shift register command, data, current contents
//   done_valid/ready      received-word handshake, done_data = word
//   busy                  any state other than IDLE
//   abort                 synchronous cancel back to IDLE
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             dir,
    input  logic [N-1:0]     load_data,
    input  logic             ser_in,
    output logic             ser_out,
    output logic [1:0]       sr_ctrl,
    output logic [N-1:0]     sr_d,
    input  logic [N-1:0]     sr_q,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [N-1:0]     done_data,
    output logic             busy,
    input  logic             abort
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    logic [N-1:0]     data_q;

    // State register; abort wins over every transition condition
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else if (abort)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_valid)     state_nxt = LOAD;
            LOAD:                       state_nxt = SHIFT;
            SHIFT: if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:  if (done_ready)      state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Shift counter and start-time latches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            dir_q  <= 1'b0;
            data_q <= '0;
        end else if (abort) begin
            cnt    <= '0;
        end else begin
            if (state == SHIFT)
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            if (state == IDLE && start_valid) begin
                dir_q  <= dir;
                data_q <= load_data;
            end
        end
    end

    // Outputs: Moore decode, except ser_out / done_data which expose sr_q
    always_comb begin
        start_ready = 1'b0;
        busy        = 1'b1;
        sr_ctrl     = SR_HOLD;
        sr_d        = '0;
        ser_out     = 1'b0;
        done_valid  = 1'b0;
        done_data   = '0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
            end
            LOAD: begin
                sr_ctrl = SR_LOAD;
                sr_d    = data_q;
            end
            SHIFT: begin
                sr_ctrl = dir_q ? SR_SHR : SR_SHL;
                // Register takes its serial input from either end of sr_d
                sr_d    = {N{ser_in}};
                ser_out = dir_q ? sr_q[0] : sr_q[N-1];
            end
            DONE: begin
                done_valid = 1'b1;
                done_data  = sr_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl with a behavioural universal shift
// register attached. Inputs change 1 time unit after a rising edge; outputs
// are checked on the falling edge.
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_valid, start_ready, dir;
    logic [N-1:0] load_data;
    logic         ser_in, ser_out;
    logic [1:0]   sr_ctrl;
    logic [N-1:0] sr_d, sr_q;
    logic         done_valid, done_ready;
    logic [N-1:0] done_data;
    logic         busy, abort;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    shift_seq_ctrl #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .dir(dir), .load_data(load_data),
        .ser_in(ser_in), .ser_out(ser_out),
        .sr_ctrl(sr_ctrl), .sr_d(sr_d), .sr_q(sr_q),
        .done_valid(done_valid), .done_ready(done_ready), .done_data(done_data),
        .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Universal shift register: serial input taken from the entering end of d
    initial sr_q = '0;
    always @(posedge clk) begin
        case (sr_ctrl)
            SR_SHL:  sr_q <= {sr_q[N-2:0], sr_d[0]};
            SR_SHR:  sr_q <= {sr_d[N-1], sr_q[N-1:1]};
            SR_LOAD: sr_q <= sr_d;
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs required while IDLE (or in reset)
    task automatic chk_idle(input string tag);
        chk({tag, " start_ready"}, N'(start_ready), N'(1));
        chk({tag, " busy"},        N'(busy),        N'(0));
        chk({tag, " sr_ctrl"},     N'(sr_ctrl),     N'(SR_HOLD));
        chk({tag, " sr_d"},        sr_d,            '0);
        chk({tag, " ser_out"},     N'(ser_out),     N'(0));
        chk({tag, " done_valid"},  N'(done_valid),  N'(0));
        chk({tag, " done_data"},   done_data,       '0);
    endtask

    // Serial bit k of the receive stream that should assemble into word rx:
    // dir=0 puts the first bit at the MSB, dir=1 at bit 0.
    function automatic logic rx_bit(input logic d, input logic [N-1:0] rx, input int k);
        return d ? rx[k] : rx[N-1-k];
    endfunction

    // Transmit order: dir=0 sends MSB first, dir=1 sends LSB first.
    function automatic logic tx_bit(input logic d, input logic [N-1:0] tx, input int k);
        return d ? tx[k] : tx[N-1-k];
    endfunction

    // One full transfer; call at edge+1 with the DUT in IDLE.
    task automatic run_xfer(input logic d, input logic [N-1:0] tx,
                            input logic [N-1:0] rx, input int bp);
        start_valid = 1'b1; dir = d; load_data = tx; done_ready = 1'b0;
        @(negedge clk);
        chk("start_ready", N'(start_ready), N'(1));
        step();
        // Scramble the inputs to show they were latched at the handshake
        start_valid = 1'b0; dir = 1'($urandom); load_data = N'($urandom);
        @(negedge clk);
        chk("load sr_ctrl", N'(sr_ctrl), N'(SR_LOAD));
        chk("load sr_d", sr_d, tx);
        chk("load busy", N'(busy), N'(1));
        for (int k = 0; k < N; k++) begin
            step();
            ser_in = rx_bit(d, rx, k);
            @(negedge clk);
            chk($sformatf("ser_out[%0d]", k), N'(ser_out), N'(tx_bit(d, tx, k)));
            chk("shift sr_ctrl", N'(sr_ctrl), N'(d ? SR_SHR : SR_SHL));
            chk("shift done_valid", N'(done_valid), N'(0));
        end
        step();
        ser_in = 1'($urandom);
        for (int i = 0; i < bp; i++) begin
            start_valid = 1'b1; // must be ignored outside IDLE
            @(negedge clk);
            chk("bp done_valid", N'(done_valid), N'(1));
            chk("bp done_data", done_data, rx);
            chk("bp start_ready", N'(start_ready), N'(0));
            chk("bp sr_ctrl", N'(sr_ctrl), N'(SR_HOLD));
            step();
        end
        start_valid = 1'b0; done_ready = 1'b1;
        @(negedge clk);
        chk("done_valid", N'(done_valid), N'(1));
        chk("done_data", done_data, rx);
        step();
        done_ready = 1'b0;
        @(negedge clk);
        chk_idle("after done");
        step();
    endtask

    initial begin
        int hs [$];
        reset = 1'b1; start_valid = 1'b0; dir = 1'b0; load_data = '0;
        ser_in = 1'b0; done_ready = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk_idle("reset");
        step();
        reset = 1'b0;
        step();

        // Directed left / right transfers
        run_xfer(1'b0, 8'hA5, 8'h3C, 0);
        run_xfer(1'b1, 8'hA5, 8'h3C, 0);
        // Backpressure
        run_xfer(1'b0, 8'h5A, 8'hC3, 5);

        // Abort in SHIFT cycle 3 together with start_valid
        start_valid = 1'b1; dir = 1'b0; load_data = 8'h81;
        step();                       // handshake
        start_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();  // LOAD, SHIFT 0..2 -> now in SHIFT 3
        abort = 1'b1; start_valid = 1'b1;
        @(negedge clk);
        chk("pre-abort busy", N'(busy), N'(1));
        step();
        abort = 1'b0; start_valid = 1'b0;
        @(negedge clk);
        chk_idle("abort");
        for (int k = 0; k < N + 2; k++) begin
            step();
            @(negedge clk);
            chk("post-abort done_valid", N'(done_valid), N'(0));
        end
        step();
        run_xfer(1'b1, 8'h96, 8'h69, 1);

        // Asynchronous reset mid-SHIFT
        start_valid = 1'b1; dir = 1'b1; load_data = 8'hF0;
        step();
        start_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        #2 reset = 1'b1;
        #1 chk_idle("async reset");
        step();
        reset = 1'b0;
        @(negedge clk);
        chk_idle("after reset");
        step();
        run_xfer(1'b0, 8'hFF, 8'hFF, 0);

        // Randomized transfers
        for (int i = 0; i < 8; i++)
            run_xfer(1'($urandom), N'($urandom), N'($urandom), int'($urandom_range(0, 3)));

        // Back-to-back: start_valid and done_ready held high
        start_valid = 1'b1; done_ready = 1'b1; load_data = 8'h3C; dir = 1'b0;
        for (int i = 0; i < 2 * (N + 3) + 2 && hs.size() < 3; i++) begin
            @(negedge clk);
            if (start_valid && start_ready) hs.push_back(cyc);
            step();
        end
        start_valid = 1'b0; done_ready = 1'b0;
        chk("b2b handshakes", N'(hs.size() >= 2), N'(1));
        if (hs.size() >= 2) chk("b2b period", N'(hs[1] - hs[0]), N'(N + 3));
        if (hs.size() >= 3) chk("b2b period2", N'(hs[2] - hs[1]), N'(N + 3));
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
